// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and encodings for the multicycle controller
package ctrl_pkg;

  // Opcode field width seen by the decoder, and wait-counter width (TIMEOUT <= 255).
  localparam int OPC_BITS = 6;
  localparam int CNT_W    = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    JUMP   = 3'd5
  } state_t;

  localparam logic [OPC_BITS-1:0] OP_AND  = 6'b100000;
  localparam logic [OPC_BITS-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_BITS-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_BITS-1:0] OP_JR   = 6'b001000;
  localparam logic [OPC_BITS-1:0] OP_JAL  = 6'b000011;
  localparam logic [OPC_BITS-1:0] OP_NOR  = 6'b100110;
  localparam logic [OPC_BITS-1:0] OP_NORI = 6'b001110;
  localparam logic [OPC_BITS-1:0] OP_NOT  = 6'b000100;
  localparam logic [OPC_BITS-1:0] OP_BLEU = 6'b010000;
  localparam logic [OPC_BITS-1:0] OP_ROLV = 6'b000000;
  localparam logic [OPC_BITS-1:0] OP_RORV = 6'b000010;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  // One-hot instruction class; exactly one bit set for a legal opcode.
  typedef struct packed {
    logic is_and;
    logic is_lw;
    logic is_sw;
    logic is_jr;
    logic is_jal;
    logic is_nor;
    logic is_nori;
    logic is_not;
    logic is_bleu;
    logic is_rolv;
    logic is_rorv;
  } ins_class_t;

  // Instructions whose result lands in rd rather than rt.
  function automatic logic writes_rd(input ins_class_t c);
    return c.is_and | c.is_nor | c.is_nori | c.is_not | c.is_rolv | c.is_rorv;
  endfunction

  // Instructions that go EXEC -> WB directly.
  function automatic logic alu_to_wb(input ins_class_t c);
    return c.is_and | c.is_nor | c.is_nori | c.is_not | c.is_rolv | c.is_rorv;
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode to one-hot instruction class decoder
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_BITS-1:0] opcode,
  output ins_class_t          cls,
  output logic                illegal
);

  // Map each defined opcode to its class bit; anything else is illegal.
  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_AND:  cls.is_and  = 1'b1;
      OP_LW:   cls.is_lw   = 1'b1;
      OP_SW:   cls.is_sw   = 1'b1;
      OP_JR:   cls.is_jr   = 1'b1;
      OP_JAL:  cls.is_jal  = 1'b1;
      OP_NOR:  cls.is_nor  = 1'b1;
      OP_NORI: cls.is_nori = 1'b1;
      OP_NOT:  cls.is_not  = 1'b1;
      OP_BLEU: cls.is_bleu = 1'b1;
      OP_ROLV: cls.is_rolv = 1'b1;
      OP_RORV: cls.is_rorv = 1'b1;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXEC/MEM/WB/JUMP controller
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int OPC_W     = 6,
  parameter int ALU_SEL_W = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   ins,
  input  logic                 alu_leu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 link,
  output logic                 alu_src,
  output logic [ALU_SEL_W-1:0] alu_op,
  output logic                 illegal,
  output logic                 mem_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OPC_BITS-1:0] opcode;
  ins_class_t          cls;
  logic                dec_illegal;

  // Ungated controls; forced low below while reset is asserted.
  logic                 mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c;
  logic [1:0]           pc_src_c;
  logic                 reg_we_c, reg_dst_c, mem_to_reg_c, link_c, alu_src_c;
  logic [ALU_SEL_W-1:0] alu_op_c;
  logic                 illegal_c, mem_err_c, busy_c;

  // Only the opcode and ALU-select fields of the instruction are consumed here.
  logic unused_ins_bits;
  assign unused_ins_bits = ^ins[INSTR_W-OPC_W-1:0];

  assign opcode = ins[INSTR_W-1 -: OPC_W];

  opcode_decode u_opcode_decode (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // State and memory wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counter and datapath enables for the current step.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = PC_SRC_SEQ;
    reg_we_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    link_c       = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = '0;
    illegal_c    = 1'b0;
    mem_err_c    = 1'b0;
    busy_c       = (state_q != FETCH);

    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_SEQ;
          state_d  = DECODE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Abort; PC is left alone so the same address is fetched again.
          mem_req_c = 1'b0;
          mem_err_c = 1'b1;
          state_d   = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DECODE: begin
        if (dec_illegal) begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end else if (cls.is_jr || cls.is_jal) begin
          state_d = JUMP;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_op_c  = ins[INSTR_W-1 -: ALU_SEL_W];
        alu_src_c = cls.is_nori | cls.is_lw | cls.is_sw;
        if (cls.is_lw || cls.is_sw) begin
          state_d = MEM;
        end else if (cls.is_bleu) begin
          if (alu_leu) begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_SRC_BRANCH;
          end
          state_d = FETCH;
        end else if (alu_to_wb(cls)) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
        end
      end

      MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = cls.is_sw;
        if (mem_ready) begin
          state_d = cls.is_lw ? WB : FETCH;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Abort the access; dropping mem_we means nothing gets written.
          mem_req_c = 1'b0;
          mem_we_c  = 1'b0;
          mem_err_c = 1'b1;
          state_d   = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = writes_rd(cls);
        mem_to_reg_c = cls.is_lw;
        state_d      = FETCH;
      end

      JUMP: begin
        pc_we_c  = 1'b1;
        pc_src_c = cls.is_jr ? PC_SRC_REG : PC_SRC_JUMP;
        if (cls.is_jal) begin
          reg_we_c = 1'b1;
          link_c   = 1'b1;
        end
        state_d = FETCH;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Reset drops every output at once so no partial write can complete.
  assign mem_req    = rst_n & mem_req_c;
  assign mem_we     = rst_n & mem_we_c;
  assign iord       = rst_n & iord_c;
  assign ir_we      = rst_n & ir_we_c;
  assign pc_we      = rst_n & pc_we_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign reg_we     = rst_n & reg_we_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign link       = rst_n & link_c;
  assign alu_src    = rst_n & alu_src_c;
  assign alu_op     = rst_n ? alu_op_c : '0;
  assign illegal    = rst_n & illegal_c;
  assign mem_err    = rst_n & mem_err_c;
  assign busy       = rst_n & busy_c;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        alu_leu;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        reg_we, reg_dst, mem_to_reg, link, alu_src;
  logic [4:0]  alu_op;
  logic        illegal, mem_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Output bundle: {mem_req, mem_we, iord, ir_we, pc_we, pc_src[1:0], reg_we,
  //                 reg_dst, mem_to_reg, link, alu_src, illegal, mem_err, busy}
  logic [14:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                 reg_dst, mem_to_reg, link, alu_src, illegal, mem_err, busy};

  localparam logic [14:0] REQ    = 15'h4000;
  localparam logic [14:0] WE     = 15'h2000;
  localparam logic [14:0] IORD   = 15'h1000;
  localparam logic [14:0] IRWE   = 15'h0800;
  localparam logic [14:0] PCWE   = 15'h0400;
  localparam logic [14:0] SRC_BR = 15'h0100;
  localparam logic [14:0] SRC_J  = 15'h0200;
  localparam logic [14:0] SRC_R  = 15'h0300;
  localparam logic [14:0] RWE    = 15'h0080;
  localparam logic [14:0] RDST   = 15'h0040;
  localparam logic [14:0] M2R    = 15'h0020;
  localparam logic [14:0] LINK   = 15'h0010;
  localparam logic [14:0] ASRC   = 15'h0008;
  localparam logic [14:0] ILL    = 15'h0004;
  localparam logic [14:0] MERR   = 15'h0002;
  localparam logic [14:0] BUSY   = 15'h0001;
  localparam logic [14:0] F_OK   = REQ | IRWE | PCWE;

  multicycle_control #(
    .INSTR_W   (32),
    .OPC_W     (6),
    .ALU_SEL_W (5),
    .TIMEOUT   (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins        (ins),
    .alu_leu    (alu_leu),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .link       (link),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .mem_err    (mem_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; ins = 32'h8C00_0000; alu_leu = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL reset_outs: got %h exp %h", outs, 15'h0); end
    n_checks++;
    if (alu_op !== 5'h0) begin n_fail++; $display("FAIL reset_alu_op: got %h exp %h", alu_op, 5'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (outs !== F_OK) begin n_fail++; $display("FAIL first_fetch: got %h exp %h", outs, F_OK); end
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic [14:0] exp_v [5];
    exp_v = '{F_OK, BUSY, ASRC | BUSY, REQ | IORD | BUSY, RWE | M2R | BUSY};
    ins = 32'h8C00_0000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL lw_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      if (i == 2) begin
        n_checks++;
        if (alu_op !== 5'h11) begin n_fail++; $display("FAIL lw_alu_op: got %h exp %h", alu_op, 5'h11); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype_and();
    logic [14:0] exp_v [4];
    exp_v = '{F_OK, BUSY, BUSY, RWE | RDST | BUSY};
    ins = 32'h8000_0000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL and_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      if (i == 2) begin
        n_checks++;
        if (alu_op !== 5'h10) begin n_fail++; $display("FAIL and_alu_op: got %h exp %h", alu_op, 5'h10); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bleu();
    logic [14:0] exp_v [6];
    logic        leu_v [6];
    exp_v = '{F_OK, BUSY, PCWE | SRC_BR | BUSY, F_OK, BUSY, BUSY};
    leu_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ins = 32'h4000_0000; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_leu = leu_v[i];
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL bleu_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      @(negedge clk);
    end
    alu_leu = 1'b0;
  endtask

  task automatic test_jumps();
    logic [31:0] ins_v [2];
    logic [14:0] exp_v [6];
    ins_v = '{32'h0C00_0000, 32'h2000_0000};
    exp_v = '{F_OK, BUSY, PCWE | SRC_J | RWE | LINK | BUSY,
              F_OK, BUSY, PCWE | SRC_R | BUSY};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ins = ins_v[i / 3];
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL jump_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_timeout();
    logic [14:0] exp_o;
    ins = 32'hAC00_0000;
    for (int pass = 0; pass < 2; pass++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== F_OK) begin n_fail++; $display("FAIL sw%0d_fetch: got %h exp %h", pass, outs, F_OK); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (outs !== BUSY) begin n_fail++; $display("FAIL sw%0d_decode: got %h exp %h", pass, outs, BUSY); end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (outs !== (ASRC | BUSY)) begin n_fail++; $display("FAIL sw%0d_exec: got %h exp %h", pass, outs, ASRC | BUSY); end
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        mem_ready = (pass == 1 && i == 15);
        exp_o = (pass == 0 && i == 15) ? (MERR | IORD | BUSY) : (REQ | WE | IORD | BUSY);
        #1;
        n_checks++;
        if (outs !== exp_o) begin n_fail++; $display("FAIL sw%0d_mem_cycle%0d: got %h exp %h", pass, i, outs, exp_o); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [14:0] exp_o;
    mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_o = (i == 15) ? MERR : REQ;
      #1;
      n_checks++;
      if (outs !== exp_o) begin n_fail++; $display("FAIL fetch_to_cycle%0d: got %h exp %h", i, outs, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [14:0] exp_v [3];
    logic        rdy_v [3];
    exp_v = '{F_OK, ILL | BUSY, REQ};
    rdy_v = '{1'b1, 1'b1, 1'b0};
    ins = 32'hFC00_0000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy_v[i];
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL illegal_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp_v [4];
    exp_v = '{F_OK, BUSY, ASRC | BUSY, REQ | IORD | BUSY};
    ins = 32'h8C00_0000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (outs !== exp_v[i]) begin n_fail++; $display("FAIL arst_step%0d: got %h exp %h", i, outs, exp_v[i]); end
      if (i < 3) @(negedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL arst_immediate: got %h exp %h", outs, 15'h0); end
    @(negedge clk);
    #1;
    n_checks++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL arst_held: got %h exp %h", outs, 15'h0); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (outs !== F_OK) begin n_fail++; $display("FAIL arst_refetch: got %h exp %h", outs, F_OK); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_and();
    test_bleu();
    test_jumps();
    test_sw_timeout();
    test_fetch_timeout();
    test_illegal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
